// File: rtl/rf_pkg.sv
// Shared constants for the parametrised register file and its scoreboard.
package rf_pkg;

    localparam int unsigned RF_DATA_W = 8;
    localparam int unsigned RF_ADDR_W = 4;
    localparam int unsigned RF_DEPTH  = 2 ** RF_ADDR_W;

    function automatic int unsigned rf_depth(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: tracks reserved destinations, flags re-reservation
// and reports read-after-write hazards on both source indices.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveDest,
    input  logic              wr_accept,
    input  logic [ADDR_W-1:0] Destin,
    input  logic [ADDR_W-1:0] Source1,
    input  logic [ADDR_W-1:0] Source2,
    output logic              Busy1,
    output logic              Busy2,
    output logic              ReserveErr
);

    localparam int unsigned DEPTH = rf_depth(ADDR_W);

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;
    logic             res_ok;
    logic             err_nxt;

    // Clear on write first so a same-edge reservation of that index survives.
    always_comb begin
        res_ok      = Reserve && !((ZERO_REG != 0) && (ReserveDest == '0));
        pending_nxt = pending;
        if (wr_accept) pending_nxt[Destin] = 1'b0;
        if (res_ok)    pending_nxt[ReserveDest] = 1'b1;
        err_nxt     = res_ok && pending[ReserveDest] &&
                      !(wr_accept && (Destin == ReserveDest));
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            pending    <= '0;
            ReserveErr <= 1'b0;
        end else begin
            pending    <= pending_nxt;
            ReserveErr <= err_nxt;
        end
    end

    // A write landing this edge resolves the hazard when it can be forwarded.
    always_comb begin
        Busy1 = pending[Source1] &&
                !((BYPASS != 0) && wr_accept && (Destin == Source1)) &&
                !((ZERO_REG != 0) && (Source1 == '0));
        Busy2 = pending[Source2] &&
                !((BYPASS != 0) && wr_accept && (Destin == Source2)) &&
                !((ZERO_REG != 0) && (Source2 == '0));
    end

endmodule

// File: rtl/param_register_file_sb.sv
// Parametrised register file with registered dual read ports, optional
// write-to-read bypass, optional zero register and a pending-write scoreboard.
module param_register_file_sb
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              RegFileRead,
    input  logic              RegFileWrite,
    input  logic [DATA_W-1:0] Datain,
    input  logic [ADDR_W-1:0] Source1,
    input  logic [ADDR_W-1:0] Source2,
    input  logic [ADDR_W-1:0] Destin,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveDest,
    output logic [DATA_W-1:0] Dataout1,
    output logic [DATA_W-1:0] Dataout2,
    output logic              RdValid,
    output logic              Busy1,
    output logic              Busy2,
    output logic              ReserveErr
);

    localparam int unsigned DEPTH = rf_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_accept;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign wr_accept = RegFileWrite && !((ZERO_REG != 0) && (Destin == '0));

    // Read value seen by each port at this edge.
    always_comb begin
        rd1 = mem[Source1];
        rd2 = mem[Source2];
        if ((BYPASS != 0) && wr_accept && (Destin == Source1)) rd1 = Datain;
        if ((BYPASS != 0) && wr_accept && (Destin == Source2)) rd2 = Datain;
        if ((ZERO_REG != 0) && (Source1 == '0)) rd1 = '0;
        if ((ZERO_REG != 0) && (Source2 == '0)) rd2 = '0;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            Dataout1 <= '0;
            Dataout2 <= '0;
            RdValid  <= 1'b0;
        end else begin
            if (wr_accept) mem[Destin] <= Datain;
            if (RegFileRead) begin
                Dataout1 <= rd1;
                Dataout2 <= rd2;
            end
            RdValid <= RegFileRead;
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .Reset       (Reset),
        .Reserve     (Reserve),
        .ReserveDest (ReserveDest),
        .wr_accept   (wr_accept),
        .Destin      (Destin),
        .Source1     (Source1),
        .Source2     (Source2),
        .Busy1       (Busy1),
        .Busy2       (Busy2),
        .ReserveErr  (ReserveErr)
    );

endmodule
